// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, stall FSM
// state and the hard-wired zero register address.
package hazard_pkg;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wren;
        logic       isload;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    localparam logic [4:0] X0 = 5'd0;

    // A source depends on an in-flight entry only if that entry really writes a
    // non-zero register with the same address.
    function automatic logic src_match(sb_entry_t e, logic used, logic [4:0] rs);
        return used & e.vld & e.wren & (e.rd != X0) & (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destination registers (entry 0 = EX). A bubble
// request loads an invalid entry instead of the ID instruction.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bubble,
    input  sb_entry_t             id_entry,
    output sb_entry_t [DEPTH-1:0] entries
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else begin
            entries[0] <= bubble ? sb_entry_t'('0) : id_entry;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard detection and ID/EX sequencing for the 5-stage core, with a stall
// FSM, a consecutive-stall watchdog and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_fwd_en,
    input  logic [4:0]       i_rs1_addr,
    input  logic [4:0]       i_rs2_addr,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    input  logic [4:0]       i_rd_addr,
    input  logic             i_rdwren,
    input  logic             i_isload,
    input  logic             i_insnvld,
    input  logic             i_br_taken_EX,
    output logic             o_stall_pc,
    output logic             o_stall_if_id,
    output logic             o_flush_if_id,
    output logic             o_flush,
    output logic             o_flush_fwd,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_err,
    output hz_state_e        o_state
);

    localparam int LEN_W = $clog2(DEPTH + 2);
    localparam logic [LEN_W-1:0] LEN_DEP = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_LIM = LEN_W'(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] sb;
    sb_entry_t             id_entry;
    logic                  m1, m2, hz, stall;
    logic [LEN_W-1:0]      len;

    assign id_entry = '{vld: i_insnvld, rd: i_rd_addr, wren: i_rdwren, isload: i_isload};

    hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .bubble   (i_br_taken_EX | hz),
        .id_entry (id_entry),
        .entries  (sb)
    );

    // With forwarding only a load still in EX cannot supply its result in time.
    always_comb begin
        m1 = 1'b0;
        m2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!i_fwd_en || (k == 0 && sb[k].isload)) begin
                m1 = m1 | src_match(sb[k], i_rs1_used, i_rs1_addr);
                m2 = m2 | src_match(sb[k], i_rs2_used, i_rs2_addr);
            end
        end
    end

    assign hz    = i_insnvld & (m1 | m2);
    assign stall = hz & ~i_br_taken_EX;

    assign o_flush_if_id = i_br_taken_EX;
    assign o_flush       = i_br_taken_EX;
    assign o_stall_pc    = stall;
    assign o_stall_if_id = stall;
    assign o_flush_fwd   = stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_state     <= RUN;
            len         <= '0;
            o_err       <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            case (o_state)
                RUN:     if (stall)  o_state <= STALL;
                STALL:   if (!stall) o_state <= RUN;
                default: o_state <= RUN;
            endcase
            // len holds the number of stall cycles already completed in this run.
            if (stall) begin
                if (len != LEN_LIM) len <= len + 1'b1;
                if (len >= LEN_DEP) o_err <= 1'b1;
            end else begin
                len <= '0;
            end
            if (stall && o_stall_cnt != '1) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a CNT_W=2 instance on
// the same ID stream for counter saturation.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fwd_en = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        u1 = 1'b0, u2 = 1'b0, wr = 1'b0, ld = 1'b0, vld = 1'b0, br = 1'b0;

    logic        stall_pc, stall_if_id, flush_if_id, flush, flush_fwd, err;
    logic [15:0] stall_cnt;
    hz_state_e   state;
    logic        s_stall_pc, s_stall_if_id, s_flush_if_id, s_flush, s_flush_fwd, s_err;
    logic [1:0]  s_stall_cnt;
    hz_state_e   s_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DEPTH(3), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_fwd_en(fwd_en),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rs1_used(u1), .i_rs2_used(u2),
        .i_rd_addr(rd), .i_rdwren(wr), .i_isload(ld), .i_insnvld(vld),
        .i_br_taken_EX(br),
        .o_stall_pc(stall_pc), .o_stall_if_id(stall_if_id), .o_flush_if_id(flush_if_id),
        .o_flush(flush), .o_flush_fwd(flush_fwd), .o_stall_cnt(stall_cnt),
        .o_err(err), .o_state(state)
    );

    hazard_ctrl #(.DEPTH(3), .CNT_W(2)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_fwd_en(fwd_en),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rs1_used(u1), .i_rs2_used(u2),
        .i_rd_addr(rd), .i_rdwren(wr), .i_isload(ld), .i_insnvld(vld),
        .i_br_taken_EX(br),
        .o_stall_pc(s_stall_pc), .o_stall_if_id(s_stall_if_id), .o_flush_if_id(s_flush_if_id),
        .o_flush(s_flush), .o_flush_fwd(s_flush_fwd), .o_stall_cnt(s_stall_cnt),
        .o_err(s_err), .o_state(s_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] a1, input logic e1, input logic [4:0] a2,
                         input logic e2, input logic [4:0] d, input logic w,
                         input logic l, input logic v);
        rs1 = a1; u1 = e1; rs2 = a2; u2 = e2; rd = d; wr = w; ld = l; vld = v;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stall_pc"},    32'(stall_pc),    0);
        check({tag, "_stall_if_id"}, 32'(stall_if_id), 0);
        check({tag, "_flush"},       32'(flush),       0);
        check({tag, "_flush_if_id"}, 32'(flush_if_id), 0);
        check({tag, "_flush_fwd"},   32'(flush_fwd),   0);
    endtask

    initial begin
        // reset state
        #12;
        check_idle("rst");
        check("rst_cnt", 32'(stall_cnt), 0);
        check("rst_err", 32'(err), 0);
        check("rst_state", 32'(state), 32'(RUN));
        #5 rst_n = 1'b1;
        cyc();

        // 1: full RAW stall without forwarding
        fwd_en = 1'b0;
        drive(1, 1, 2, 1, 5, 1, 0, 1);          // ADD x5,x1,x2
        #2 check("t1_prod_nostall", 32'(stall_pc), 0);
        cyc();
        drive(5, 1, 1, 1, 6, 1, 0, 1);          // ADD x6,x5,x1
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("t1_stall%0d", i), 32'(stall_pc), 1);
            check($sformatf("t1_fwd%0d", i), 32'(flush_fwd), 1);
            cyc();
        end
        #2;
        check("t1_release", 32'(stall_pc), 0);
        check("t1_state", 32'(state), 32'(STALL));
        check("t1_cnt", 32'(stall_cnt), 3);
        check("t1_cnt_s", 32'(s_stall_cnt), 3);
        check("t1_err", 32'(err), 0);
        cyc();
        drain();
        check("t1_state_run", 32'(state), 32'(RUN));

        // 2: forwarding, load-use only
        fwd_en = 1'b1;
        drive(1, 1, 0, 0, 7, 1, 1, 1);          // LW x7
        cyc();
        drive(7, 1, 0, 1, 8, 1, 0, 1);          // ADD x8,x7,x0
        #2 check("t2_lu_stall", 32'(stall_pc), 1);
        cyc();
        #2 check("t2_lu_release", 32'(stall_pc), 0);
        check("t2_cnt", 32'(stall_cnt), 4);
        check("t2_cnt_sat", 32'(s_stall_cnt), 3);
        cyc();
        drain();
        drive(1, 1, 2, 1, 7, 1, 0, 1);          // ADD x7
        cyc();
        drive(7, 1, 0, 1, 8, 1, 0, 1);
        #2 check("t2_alu_nostall", 32'(stall_pc), 0);
        cyc();
        drain();

        // 3: x0 never hazards
        fwd_en = 1'b0;
        drive(1, 1, 2, 1, 0, 1, 0, 1);          // ADD x0,x1,x2
        cyc();
        drive(0, 1, 0, 1, 9, 1, 0, 1);          // ADD x9,x0,x0
        #2 check("t3_x0", 32'(stall_pc), 0);
        cyc();
        check("t3_cnt", 32'(stall_cnt), 4);
        drain();

        // 4: branch beats hazard, squashed slot becomes a bubble
        fwd_en = 1'b1;
        drive(0, 0, 0, 0, 9, 1, 1, 1);          // LW x9
        cyc();
        drive(9, 1, 0, 0, 10, 1, 1, 1);         // LW x10,(x9) while branch taken
        br = 1'b1;
        #2;
        check("t4_flush", 32'(flush), 1);
        check("t4_flush_if_id", 32'(flush_if_id), 1);
        check("t4_stall_pc", 32'(stall_pc), 0);
        check("t4_stall_if_id", 32'(stall_if_id), 0);
        check("t4_flush_fwd", 32'(flush_fwd), 0);
        cyc();
        br = 1'b0;
        drive(10, 1, 0, 0, 11, 1, 0, 1);        // reads x10: squashed, so no stall
        #2;
        check("t4_bubble", 32'(stall_pc), 0);
        check("t4_cnt", 32'(stall_cnt), 4);
        check("t4_state", 32'(state), 32'(RUN));
        cyc();
        drain();

        // 5: async reset in the second stall cycle
        fwd_en = 1'b0;
        drive(1, 1, 2, 1, 5, 1, 0, 1);
        cyc();
        drive(5, 1, 0, 0, 6, 1, 0, 1);
        cyc();
        #1 check("t5_stall2", 32'(stall_pc), 1);
        rst_n = 1'b0;
        #1;
        check_idle("t5_rst");
        check("t5_rst_cnt", 32'(stall_cnt), 0);
        #1 rst_n = 1'b1;
        cyc();
        #2;
        check("t5_state", 32'(state), 32'(RUN));
        check("t5_cnt", 32'(stall_cnt), 0);
        check("t5_nostall", 32'(stall_pc), 0);
        cyc();
        drain();

        // 6: forced hold of DEPTH+1 stall cycles trips the sticky watchdog
        force dut.hz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 check($sformatf("t6_err_pre%0d", i), 32'(err), 0);
            cyc();
        end
        release dut.hz;
        #2;
        check("t6_err_set", 32'(err), 1);
        check("t6_cnt", 32'(stall_cnt), 4);
        check("t6_no_stall", 32'(stall_pc), 0);
        check("t6_s_err", 32'(s_err), 0);
        cyc();
        cyc();
        #2 check("t6_err_sticky", 32'(err), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
